// File: rtl/pipe_hazard_ctrl_if.sv
// Control bus between the pipeline datapath and pipe_hazard_ctrl.
// The datapath side uses the master modport; the hazard controller uses the slave modport.
interface pipe_hazard_ctrl_if #(
  parameter int RA_W   = 5,
  parameter int FSEL_W = 2,
  parameter int CNT_W  = 32
);
  logic              id_valid;
  logic [RA_W-1:0]   id_rs1;
  logic [RA_W-1:0]   id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [RA_W-1:0]   id_rd;
  logic              id_regwrite;
  logic              id_memread;
  logic              mem_access;
  logic              dmem_ready;
  logic              branch_taken;

  logic              pc_write;
  logic              if_id_write;
  logic              id_ex_bubble;
  logic              flush_young;
  logic              freeze;
  logic [FSEL_W-1:0] fwd_a;
  logic [FSEL_W-1:0] fwd_b;
  logic [CNT_W-1:0]  perf_stall;
  logic [CNT_W-1:0]  perf_freeze;
  logic [CNT_W-1:0]  perf_flush;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_regwrite, id_memread, mem_access, dmem_ready, branch_taken,
    input  pc_write, if_id_write, id_ex_bubble, flush_young, freeze,
           fwd_a, fwd_b, perf_stall, perf_freeze, perf_flush
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_regwrite, id_memread, mem_access, dmem_ready, branch_taken,
    output pc_write, if_id_write, id_ex_bubble, flush_young, freeze,
           fwd_a, fwd_b, perf_stall, perf_freeze, perf_flush
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Combined hazard / forwarding controller for the 5-stage RV32I pipeline.
// Define PIPE_HAZARD_PERF_EN to build the stall/freeze/flush event counters.
module pipe_hazard_ctrl #(
  parameter int NFWD   = 2,
  parameter int RA_W   = 5,
  parameter int FSEL_W = 2,
  parameter int CNT_W  = 32
) (
  input logic               clk,
  input logic               reset,
  pipe_hazard_ctrl_if.slave bus
);

  // Slot 0 is EX; slot k is k stages past EX. Only EX needs its sources and load flag.
  logic [NFWD:0]   slot_valid;
  logic [NFWD:0]   slot_regwrite;
  logic [RA_W-1:0] slot_rd [NFWD+1];
  logic            ex_memread;
  logic [RA_W-1:0] ex_rs1;
  logic [RA_W-1:0] ex_rs2;

  logic              freeze;
  logic              flush;
  logic              load_use;
  logic              stall;
  logic [FSEL_W-1:0] fwd_a;
  logic [FSEL_W-1:0] fwd_b;

  always_comb begin
    freeze   = ~reset & bus.mem_access & ~bus.dmem_ready;
    flush    = ~reset & bus.branch_taken & ~freeze;
    load_use = bus.id_valid & slot_valid[0] & ex_memread & (slot_rd[0] != '0) &
               ((bus.id_use_rs1 & (bus.id_rs1 == slot_rd[0])) |
                (bus.id_use_rs2 & (bus.id_rs2 == slot_rd[0])));
    stall    = ~reset & load_use & ~freeze & ~flush;
  end

  // Scan oldest to youngest so the youngest matching producer is the last to assign.
  always_comb begin
    fwd_a = '0;
    fwd_b = '0;
    for (int k = NFWD; k >= 1; k--) begin
      if (slot_valid[k] && slot_regwrite[k] && (slot_rd[k] != '0)) begin
        if (slot_rd[k] == ex_rs1) fwd_a = FSEL_W'(k);
        if (slot_rd[k] == ex_rs2) fwd_b = FSEL_W'(k);
      end
    end
    if (reset || !slot_valid[0]) begin
      fwd_a = '0;
      fwd_b = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_valid    <= '0;
      slot_regwrite <= '0;
      for (int k = 0; k <= NFWD; k++) slot_rd[k] <= '0;
      ex_memread    <= 1'b0;
      ex_rs1        <= '0;
      ex_rs2        <= '0;
    end else if (!freeze) begin
      slot_valid[0]    <= bus.id_valid & ~stall & ~flush;
      slot_regwrite[0] <= bus.id_regwrite;
      slot_rd[0]       <= bus.id_rd;
      ex_memread       <= bus.id_memread;
      ex_rs1           <= bus.id_rs1;
      ex_rs2           <= bus.id_rs2;
      // A taken branch also kills the instruction leaving EX for MEM.
      for (int k = 1; k <= NFWD; k++) begin
        slot_valid[k]    <= slot_valid[k-1] & ~(flush & (k == 1));
        slot_regwrite[k] <= slot_regwrite[k-1];
        slot_rd[k]       <= slot_rd[k-1];
      end
    end
  end

  assign bus.freeze       = freeze;
  assign bus.flush_young  = flush;
  assign bus.id_ex_bubble = stall;
  assign bus.pc_write     = ~freeze & ~stall;
  assign bus.if_id_write  = ~freeze & ~stall;
  assign bus.fwd_a        = fwd_a;
  assign bus.fwd_b        = fwd_b;

`ifdef PIPE_HAZARD_PERF_EN
  logic [CNT_W-1:0] perf_stall_q;
  logic [CNT_W-1:0] perf_freeze_q;
  logic [CNT_W-1:0] perf_flush_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_q  <= '0;
      perf_freeze_q <= '0;
      perf_flush_q  <= '0;
    end else begin
      if (stall)  perf_stall_q  <= perf_stall_q + CNT_W'(1);
      if (freeze) perf_freeze_q <= perf_freeze_q + CNT_W'(1);
      if (flush)  perf_flush_q  <= perf_flush_q + CNT_W'(1);
    end
  end

  assign bus.perf_stall  = perf_stall_q;
  assign bus.perf_freeze = perf_freeze_q;
  assign bus.perf_flush  = perf_flush_q;
`else
  assign bus.perf_stall  = '0;
  assign bus.perf_freeze = '0;
  assign bus.perf_flush  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed vector table, then random traffic
// checked against an in-flight instruction queue model.
module tb_pipe_hazard_ctrl;
  localparam int NFWD   = 2;
  localparam int RA_W   = 5;
  localparam int FSEL_W = 2;
  localparam int CNT_W  = 32;

  logic clk = 1'b0;
  logic reset;

  pipe_hazard_ctrl_if #(.RA_W(RA_W), .FSEL_W(FSEL_W), .CNT_W(CNT_W)) bus ();

  pipe_hazard_ctrl #(.NFWD(NFWD), .RA_W(RA_W), .FSEL_W(FSEL_W), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v; logic [4:0] rd; logic rw; logic mr;
    logic [4:0] rs1; logic u1; logic [4:0] rs2; logic u2;
    logic ma; logic rdy; logic br;
  } stim_t;

  typedef struct {
    logic pcw; logic ifw; logic bub; logic fl; logic fz;
    logic [1:0] fa; logic [1:0] fb;
  } exp_t;

  typedef struct { stim_t s; exp_t e; } vec_t;

  typedef struct { bit v; bit [4:0] rd; bit rw; bit mr; bit [4:0] rs1; bit [4:0] rs2; } ins_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: queue of in-flight instructions, entry 0 in EX, entry k k stages later.
  ins_t      flight[$];
  bit [31:0] m_stall, m_freeze, m_flush;

  function automatic stim_t st(bit v, int rd, bit rw, bit mr, int rs1, bit u1, int rs2, bit u2,
                               bit ma = 0, bit rdy = 1, bit br = 0);
    stim_t s;
    s = '{v: v, rd: 5'(rd), rw: rw, mr: mr, rs1: 5'(rs1), u1: u1, rs2: 5'(rs2), u2: u2,
          ma: ma, rdy: rdy, br: br};
    return s;
  endfunction

  function automatic exp_t ex(bit pcw, bit ifw, bit bub, bit fl, bit fz, int fa, int fb);
    exp_t e;
    e = '{pcw: pcw, ifw: ifw, bub: bub, fl: fl, fz: fz, fa: 2'(fa), fb: 2'(fb)};
    return e;
  endfunction

  function automatic exp_t nrm(int fa, int fb);
    return ex(1, 1, 0, 0, 0, fa, fb);
  endfunction

  function automatic bit [31:0] pexp(bit [31:0] v);
`ifdef PIPE_HAZARD_PERF_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  function automatic exp_t model_out(stim_t s);
    exp_t e;
    ins_t x;
    bit   lu, fa_found, fb_found;
    x = flight[0];
    e.fz  = s.ma && !s.rdy;
    e.fl  = s.br && !e.fz;
    lu    = s.v && x.v && x.mr && (x.rd != 0) &&
            ((s.u1 && s.rs1 == x.rd) || (s.u2 && s.rs2 == x.rd));
    e.bub = lu && !e.fz && !e.fl;
    e.pcw = !e.fz && !e.bub;
    e.ifw = e.pcw;
    e.fa = 0; e.fb = 0; fa_found = 0; fb_found = 0;
    if (x.v) begin
      for (int k = 1; k <= NFWD; k++) begin
        if (flight[k].v && flight[k].rw && flight[k].rd != 0) begin
          if (!fa_found && flight[k].rd == x.rs1) begin e.fa = 2'(k); fa_found = 1; end
          if (!fb_found && flight[k].rd == x.rs2) begin e.fb = 2'(k); fb_found = 1; end
        end
      end
    end
    return e;
  endfunction

  function automatic void model_step(stim_t s);
    exp_t e;
    ins_t n;
    e = model_out(s);
    if (e.fz) begin
      m_freeze++;
      return;
    end
    n = '{v: s.v && !e.bub && !e.fl, rd: s.rd, rw: s.rw, mr: s.mr, rs1: s.rs1, rs2: s.rs2};
    if (e.fl) begin
      flight[0].v = 0;
      m_flush++;
    end
    if (e.bub) m_stall++;
    flight.push_front(n);
    void'(flight.pop_back());
  endfunction

  function automatic void model_reset();
    ins_t z;
    z = '{v: 0, rd: 0, rw: 0, mr: 0, rs1: 0, rs2: 0};
    flight.delete();
    for (int k = 0; k <= NFWD; k++) flight.push_back(z);
    m_stall = 0; m_freeze = 0; m_flush = 0;
  endfunction

  task automatic applyStimulus(stim_t s);
    bus.id_valid     = s.v;
    bus.id_rd        = s.rd;
    bus.id_regwrite  = s.rw;
    bus.id_memread   = s.mr;
    bus.id_rs1       = s.rs1;
    bus.id_use_rs1   = s.u1;
    bus.id_rs2       = s.rs2;
    bus.id_use_rs2   = s.u2;
    bus.mem_access   = s.ma;
    bus.dmem_ready   = s.rdy;
    bus.branch_taken = s.br;
  endtask

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic checkAll(string tag, exp_t e);
    checkOutput({tag, " pc_write"},     32'(bus.pc_write),     32'(e.pcw));
    checkOutput({tag, " if_id_write"},  32'(bus.if_id_write),  32'(e.ifw));
    checkOutput({tag, " id_ex_bubble"}, 32'(bus.id_ex_bubble), 32'(e.bub));
    checkOutput({tag, " flush_young"},  32'(bus.flush_young),  32'(e.fl));
    checkOutput({tag, " freeze"},       32'(bus.freeze),       32'(e.fz));
    checkOutput({tag, " fwd_a"},        32'(bus.fwd_a),        32'(e.fa));
    checkOutput({tag, " fwd_b"},        32'(bus.fwd_b),        32'(e.fb));
  endtask

  task automatic checkPerf(string tag, bit [31:0] s, bit [31:0] f, bit [31:0] fl);
    checkOutput({tag, " perf_stall"},  bus.perf_stall,  pexp(s));
    checkOutput({tag, " perf_freeze"}, bus.perf_freeze, pexp(f));
    checkOutput({tag, " perf_flush"},  bus.perf_flush,  pexp(fl));
  endtask

  // Inputs change just after the rising edge; outputs are checked on the falling edge.
  task automatic runCycle(stim_t s, exp_t e, string tag);
    applyStimulus(s);
    @(negedge clk);
    checkAll(tag, e);
    model_step(s);
    @(posedge clk);
    #1;
  endtask

  // Freeze and branch requests are driven during reset to show reset dominates them.
  task automatic doReset();
    reset = 1'b1;
    applyStimulus(st(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
    @(posedge clk);
    #1;
    checkAll("reset", ex(1, 1, 0, 0, 0, 0, 0));
    checkPerf("reset", 0, 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(st(0, 0, 0, 0, 0, 0, 0, 0));
    model_reset();
  endtask

  vec_t  tbl[28];
  stim_t rs;

  initial begin
    tbl[0]  = '{s: st(0, 0, 0, 0, 0, 0, 0, 0),        e: nrm(0, 0)};
    tbl[1]  = '{s: st(1, 5, 1, 0, 1, 1, 2, 1),        e: nrm(0, 0)};
    tbl[2]  = '{s: st(1, 7, 1, 0, 5, 1, 3, 1),        e: nrm(0, 0)};
    tbl[3]  = '{s: st(1, 8, 1, 0, 5, 1, 9, 1),        e: nrm(1, 0)};
    tbl[4]  = '{s: st(0, 0, 0, 0, 0, 0, 0, 0),        e: nrm(2, 0)};
    tbl[5]  = '{s: st(1, 5, 1, 0, 0, 0, 0, 0),        e: nrm(0, 0)};
    tbl[6]  = '{s: st(1, 5, 1, 0, 0, 0, 0, 0),        e: nrm(0, 0)};
    tbl[7]  = '{s: st(1, 10, 1, 0, 5, 1, 5, 1),       e: nrm(0, 0)};
    tbl[8]  = '{s: st(0, 0, 0, 0, 0, 0, 0, 0),        e: nrm(1, 1)};
    tbl[9]  = '{s: st(1, 6, 1, 1, 1, 1, 0, 0),        e: nrm(0, 0)};
    tbl[10] = '{s: st(1, 11, 1, 0, 2, 1, 6, 1),       e: ex(0, 0, 1, 0, 0, 0, 0)};
    tbl[11] = '{s: st(1, 11, 1, 0, 2, 1, 6, 1),       e: nrm(0, 0)};
    tbl[12] = '{s: st(0, 0, 0, 0, 0, 0, 0, 0),        e: nrm(0, 2)};
    tbl[13] = '{s: st(1, 0, 1, 1, 1, 1, 0, 0),        e: nrm(0, 0)};
    tbl[14] = '{s: st(1, 12, 1, 0, 0, 1, 0, 1),       e: nrm(0, 0)};
    tbl[15] = '{s: st(0, 0, 0, 0, 0, 0, 0, 0),        e: nrm(0, 0)};
    tbl[16] = '{s: st(1, 13, 1, 0, 0, 0, 0, 0),       e: nrm(0, 0)};
    tbl[17] = '{s: st(1, 14, 1, 0, 13, 1, 12, 1),     e: nrm(0, 0)};
    tbl[18] = '{s: st(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), e: ex(0, 0, 0, 0, 1, 1, 0)};
    tbl[19] = '{s: st(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1), e: ex(0, 0, 0, 0, 1, 1, 0)};
    tbl[20] = '{s: st(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1), e: ex(0, 0, 0, 0, 1, 1, 0)};
    tbl[21] = '{s: st(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1), e: ex(1, 1, 0, 1, 0, 1, 0)};
    tbl[22] = '{s: st(1, 15, 1, 0, 13, 1, 0, 0),      e: nrm(0, 0)};
    tbl[23] = '{s: st(0, 0, 0, 0, 0, 0, 0, 0),        e: nrm(0, 0)};
    tbl[24] = '{s: st(1, 16, 1, 1, 0, 0, 0, 0),       e: nrm(0, 0)};
    tbl[25] = '{s: st(1, 17, 1, 0, 16, 1, 0, 0, 0, 1, 1), e: ex(1, 1, 0, 1, 0, 0, 0)};
    tbl[26] = '{s: st(1, 18, 1, 0, 16, 1, 15, 1),     e: nrm(0, 0)};
    tbl[27] = '{s: st(0, 0, 0, 0, 0, 0, 0, 0),        e: nrm(0, 0)};

    doReset();
    for (int i = 0; i < 28; i++) runCycle(tbl[i].s, tbl[i].e, $sformatf("vec%0d", i));
    checkPerf("table", 1, 3, 2);

    // Random traffic with a narrow register range to provoke frequent hazards.
    doReset();
    for (int i = 0; i < 600; i++) begin
      rs = st($urandom_range(0, 9) < 8, $urandom_range(0, 5), $urandom_range(0, 3) != 0,
              $urandom_range(0, 2) == 0, $urandom_range(0, 5), $urandom_range(0, 1),
              $urandom_range(0, 5), $urandom_range(0, 1), $urandom_range(0, 2) == 0,
              $urandom_range(0, 1), $urandom_range(0, 9) == 0);
      runCycle(rs, model_out(rs), $sformatf("rnd%0d", i));
      checkPerf($sformatf("rnd%0d", i), m_stall, m_freeze, m_flush);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
